// File: rtl/uvc_payload_packer.sv
// uvc_payload_packer
// Packs 32-bit YUY2 words from the show-ahead YUV FIFO into UVC bulk payloads.
// Each payload is a 12-byte UVC header (three words) followed by up to
// PAYLOAD_WORDS data words. Frame position is tracked so that FID, EOF,
// PTS and SCR are correct in every header.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   cam_active       host has committed streaming; low aborts the stream
//   fifo_dout/empty  show-ahead FIFO head word and empty flag
//   fifo_rd_en       pops the FIFO head (only in DATA, on an accepted word)
//   sof_cnt          USB frame number, sampled into the SCR field
//   out_data/valid/ready/last  valid/ready stream toward the bulk-IN endpoint
//   fid              current frame ID, for debug
//
// The stream outputs are decoded combinationally from the registered state so
// that a falling cam_active or an empty FIFO gates out_valid in the same cycle.
module uvc_payload_packer #(
    parameter int unsigned WIDTH         = 1280,
    parameter int unsigned HEIGHT        = 720,
    parameter int unsigned PAYLOAD_WORDS = 4093
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_active,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [10:0] sof_cnt,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        fid
);

    localparam int unsigned FRAME_CNT_W = 24;
    localparam int unsigned PAY_CNT_W   = 16;
    localparam int unsigned STC_W       = 32;
    localparam int unsigned SOF_W       = 11;
    localparam int unsigned FRAME_WORDS = WIDTH * HEIGHT / 2;

    localparam logic [FRAME_CNT_W-1:0] FRAME_WORDS_C   = FRAME_CNT_W'(FRAME_WORDS);
    localparam logic [FRAME_CNT_W-1:0] PAYLOAD_WORDS_F = FRAME_CNT_W'(PAYLOAD_WORDS);
    localparam logic [PAY_CNT_W-1:0]   PAYLOAD_WORDS_P = PAY_CNT_W'(PAYLOAD_WORDS);
    localparam logic [7:0]             HDR_LEN         = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_DATA
    } state_t;

    state_t                 state_q,     state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [PAY_CNT_W-1:0]   pay_cnt_q,   pay_cnt_d;
    logic [PAY_CNT_W-1:0]   pay_len_q,   pay_len_d;
    logic [STC_W-1:0]       stc_q,       stc_d;
    logic [STC_W-1:0]       stc_l_q,     stc_l_d;
    logic [STC_W-1:0]       pts_q,       pts_d;
    logic [SOF_W-1:0]       sof_l_q,     sof_l_d;
    logic                   eof_q,       eof_d;
    logic                   fid_q,       fid_d;

    logic [FRAME_CNT_W-1:0] frame_rem_c;
    logic [7:0]             bfh_c;
    logic                   accept_c;

    // Words still owed to the current frame, and the header flags byte
    assign frame_rem_c = FRAME_WORDS_C - frame_cnt_q;
    assign bfh_c       = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, eof_q, fid_q};
    assign accept_c    = out_valid && out_ready;
    assign fid         = fid_q;

    // Stream output decode
    always_comb begin : comb_out
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        fifo_rd_en = 1'b0;
        case (state_q)
            ST_HDR0: begin
                out_valid = cam_active;
                out_data  = {pts_q[15:0], bfh_c, HDR_LEN};
            end
            ST_HDR1: begin
                out_valid = cam_active;
                out_data  = {stc_l_q[15:0], pts_q[31:16]};
            end
            ST_HDR2: begin
                out_valid = cam_active;
                out_data  = {5'b0, sof_l_q, stc_l_q[31:16]};
            end
            ST_DATA: begin
                out_valid  = cam_active && !fifo_empty;
                out_data   = fifo_dout;
                out_last   = (pay_cnt_q == pay_len_q - PAY_CNT_W'(1));
                fifo_rd_en = cam_active && !fifo_empty && out_ready;
            end
            default: ;
        endcase
    end

    // Next-state and counter update
    always_comb begin : comb_next
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        pay_len_d   = pay_len_q;
        stc_d       = stc_q + STC_W'(1);
        stc_l_d     = stc_l_q;
        pts_d       = pts_q;
        sof_l_d     = sof_l_q;
        eof_d       = eof_q;
        fid_d       = fid_q;

        if (!cam_active) begin
            // Abort: drop the partial payload and restart the frame count
            state_d     = ST_IDLE;
            pay_cnt_d   = '0;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_d   = ST_HDR0;
                        pay_len_d = (frame_rem_c > PAYLOAD_WORDS_F) ? PAYLOAD_WORDS_P
                                                                    : PAY_CNT_W'(frame_rem_c);
                        eof_d     = (frame_rem_c <= PAYLOAD_WORDS_F);
                        stc_l_d   = stc_q;
                        sof_l_d   = sof_cnt;
                        // PTS is captured once per frame, at its first payload
                        if (frame_cnt_q == '0) begin
                            pts_d = stc_q;
                        end
                    end
                end
                ST_HDR0: if (accept_c) state_d = ST_HDR1;
                ST_HDR1: if (accept_c) state_d = ST_HDR2;
                ST_HDR2: if (accept_c) state_d = ST_DATA;
                ST_DATA: begin
                    if (accept_c) begin
                        pay_cnt_d   = pay_cnt_q + PAY_CNT_W'(1);
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                        if (out_last) begin
                            state_d   = ST_IDLE;
                            pay_cnt_d = '0;
                            if (eof_q) begin
                                frame_cnt_d = '0;
                                fid_d       = ~fid_q;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin : seq
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            pay_cnt_q   <= '0;
            pay_len_q   <= '0;
            stc_q       <= '0;
            stc_l_q     <= '0;
            pts_q       <= '0;
            sof_l_q     <= '0;
            eof_q       <= 1'b0;
            fid_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            pay_len_q   <= pay_len_d;
            stc_q       <= stc_d;
            stc_l_q     <= stc_l_d;
            pts_q       <= pts_d;
            sof_l_q     <= sof_l_d;
            eof_q       <= eof_d;
            fid_q       <= fid_d;
        end
    end

endmodule

// File: tb/tb_uvc_payload_packer.sv
// Bench for uvc_payload_packer: 8x4 frame (16 words) in payloads of at most 6.
// A queue-based FIFO model feeds the DUT; expected data words and payload
// layouts are queued as stimulus is created and popped as words are accepted.
`timescale 1ns/1ps
module tb_uvc_payload_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cam_active;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [10:0] sof_cnt;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        fid;

    always #5 clk = ~clk;

    uvc_payload_packer #(
        .WIDTH         (8),
        .HEIGHT        (4),
        .PAYLOAD_WORDS (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cam_active (cam_active),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .sof_cnt    (sof_cnt),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fid        (fid)
    );

    typedef struct {
        logic [7:0]  bfh;
        bit          first;
        int unsigned n;
    } pl_t;

    pl_t         pl_q[$];
    logic [31:0] data_q[$];
    logic [31:0] fifo_q[$];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] tb_stc;
    bit          force_empty;

    int          mon_pos;
    bit          hdr_live;
    pl_t         cur;
    logic [31:0] exp_stc_l;
    logic [31:0] exp_pts;
    int unsigned didx;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    int          data_cnt;
    int          rd_cnt;
    logic [31:0] last_hdr_pts;

    logic        s_valid, s_rd, s_last;
    logic [31:0] s_data;

    task automatic mon_clear();
        mon_pos    = 0;
        hdr_live   = 1'b0;
        didx       = 0;
        prev_stall = 1'b0;
        cur.bfh    = 8'h00;
        cur.first  = 1'b0;
        cur.n      = 1;
    endtask

    task automatic push_layout(input logic f);
        pl_t p;
        p.first = 1'b1; p.n = 6; p.bfh = 8'h8C | {7'b0, f};
        pl_q.push_back(p);
        p.first = 1'b0;
        pl_q.push_back(p);
        p.n = 4; p.bfh = 8'h8E | {7'b0, f};
        pl_q.push_back(p);
    endtask

    task automatic push_words(input logic [31:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            fifo_q.push_back(base + 32'(i));
            data_q.push_back(base + 32'(i));
        end
    endtask

    // One clock: drive FIFO model at negedge, sample/score at +1, pop after posedge
    task automatic cycle();
        logic [31:0] exp_w;
        logic        exp_rd;
        logic        exp_last;
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
        sof_cnt    = 11'(tb_stc) ^ 11'h5A5;
        #1;
        s_valid = out_valid;
        s_rd    = fifo_rd_en;
        s_data  = out_data;
        s_last  = out_last;

        if (prev_stall && s_valid) begin
            vectors++;
            if (s_data !== prev_data || s_last !== prev_last) begin
                miscompares++;
                $display("FAIL hold: data %h last %b, required %h %b", s_data, s_last, prev_data, prev_last);
            end
        end

        exp_rd = (mon_pos == 3) && s_valid && out_ready;
        vectors++;
        if (s_rd !== exp_rd) begin
            miscompares++;
            $display("FAIL rd_en: got %b, required %b (pos %0d)", s_rd, exp_rd, mon_pos);
        end

        if (mon_pos == 0 && s_valid && !hdr_live) begin
            hdr_live  = 1'b1;
            exp_stc_l = tb_stc - 32'd1;
            vectors++;
            if (pl_q.size() == 0) begin
                miscompares++;
                $display("FAIL extra_payload: header appeared, required none");
            end else begin
                cur = pl_q.pop_front();
            end
            if (cur.first) exp_pts = exp_stc_l;
            last_hdr_pts = exp_pts;
        end

        if (s_valid && out_ready) begin
            case (mon_pos)
                0, 1, 2: begin
                    if (mon_pos == 0)      exp_w = {exp_pts[15:0], cur.bfh, 8'h0C};
                    else if (mon_pos == 1) exp_w = {exp_stc_l[15:0], exp_pts[31:16]};
                    else                   exp_w = {5'b0, 11'(exp_stc_l) ^ 11'h5A5, exp_stc_l[31:16]};
                    vectors++;
                    if (s_data !== exp_w || s_last !== 1'b0) begin
                        miscompares++;
                        $display("FAIL hdr%0d: got %h last %b, required %h last 0", mon_pos, s_data, s_last, exp_w);
                    end
                    mon_pos = mon_pos + 1;
                    didx    = 0;
                end
                default: begin
                    vectors++;
                    if (data_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL data: got %h, required no word", s_data);
                    end else begin
                        exp_w = data_q.pop_front();
                        if (s_data !== exp_w) begin
                            miscompares++;
                            $display("FAIL data: got %h, required %h", s_data, exp_w);
                        end
                    end
                    exp_last = (didx == cur.n - 1);
                    vectors++;
                    if (s_last !== exp_last) begin
                        miscompares++;
                        $display("FAIL last: word %0d got %b, required %b", didx, s_last, exp_last);
                    end
                    didx++;
                    data_cnt++;
                    if (didx == cur.n) begin
                        mon_pos  = 0;
                        hdr_live = 1'b0;
                    end
                end
            endcase
        end

        prev_stall = s_valid && !out_ready;
        prev_data  = s_data;
        prev_last  = s_last;

        @(posedge clk);
        if (rst_n) tb_stc++;
        if (s_rd) begin
            rd_cnt++;
            if (fifo_q.size() != 0) fifo_q.delete(0);
        end
        @(negedge clk);
    endtask

    task automatic run_data(input int target, input int budget, input bit toggle, output int ncyc);
        int start;
        start = data_cnt;
        ncyc  = 0;
        while ((data_cnt - start) < target && ncyc < budget) begin
            if (toggle) out_ready = ~out_ready;
            cycle();
            ncyc++;
        end
        vectors++;
        if ((data_cnt - start) < target) begin
            miscompares++;
            $display("FAIL timeout: %0d of %0d data words in %0d cycles", data_cnt - start, target, ncyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; cam_active = 1'b0; out_ready = 1'b1; fifo_empty = 1'b1;
        fifo_dout = '0; sof_cnt = '0; force_empty = 1'b0; tb_stc = '0;
        data_cnt = 0; rd_cnt = 0; last_hdr_pts = '0; exp_pts = '0;
        mon_clear();
        #1 rst_n = 1'b0;
        #2 cam_active = 1'b1; fifo_empty = 1'b0; fifo_dout = 32'hCAFE_F00D;
        @(negedge clk); #1;
        vectors++;
        if ({out_valid, out_last, fifo_rd_en, fid, out_data} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v%b l%b rd%b fid%b d%h, required all 0",
                     out_valid, out_last, fifo_rd_en, fid, out_data);
        end
        @(negedge clk);
        cam_active = 1'b0;
        rst_n      = 1'b1;
        tb_stc     = '0;
        cycle();
        vectors++;
        if (s_valid !== 1'b0 || fid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: valid %b fid %b, required 0 0", s_valid, fid);
        end
    endtask

    task automatic test_small_frame(output logic [31:0] pts1);
        int n;
        push_words(32'h0, 16);
        push_layout(1'b0);
        cam_active = 1'b1; out_ready = 1'b1;
        run_data(16, 100, 1'b0, n);
        vectors++;
        if (n != 28) begin miscompares++; $display("FAIL frame1_cycles: got %0d, required 28", n); end
        vectors++;
        if (fid !== 1'b1) begin miscompares++; $display("FAIL frame1_fid: got %b, required 1", fid); end
        vectors++;
        if (pl_q.size() != 0) begin miscompares++; $display("FAIL frame1_payloads: %0d left, required 0", pl_q.size()); end
        pts1 = last_hdr_pts;
    endtask

    task automatic test_second_frame(input logic [31:0] pts1);
        int n;
        push_words(32'd16, 16);
        push_layout(1'b1);
        run_data(16, 100, 1'b0, n);
        vectors++;
        if (n != 28) begin miscompares++; $display("FAIL frame2_cycles: got %0d, required 28", n); end
        vectors++;
        if (fid !== 1'b0) begin miscompares++; $display("FAIL frame2_fid: got %b, required 0", fid); end
        vectors++;
        if (last_hdr_pts == pts1) begin miscompares++; $display("FAIL frame2_pts: got %h, required != %h", last_hdr_pts, pts1); end
    endtask

    task automatic test_backpressure();
        int n;
        int rd0;
        rd0 = rd_cnt;
        push_words(32'h100, 16);
        push_layout(1'b0);
        out_ready = 1'b0;
        run_data(16, 200, 1'b1, n);
        out_ready = 1'b1;
        vectors++;
        if (rd_cnt - rd0 != 16) begin miscompares++; $display("FAIL bp_pops: got %0d, required 16", rd_cnt - rd0); end
        vectors++;
        if (fid !== 1'b1) begin miscompares++; $display("FAIL bp_fid: got %b, required 1", fid); end
    endtask

    task automatic test_underrun();
        int n;
        push_words(32'h200, 16);
        push_layout(1'b1);
        run_data(2, 50, 1'b0, n);
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            vectors++;
            if (s_valid !== 1'b0 || s_rd !== 1'b0) begin
                miscompares++;
                $display("FAIL underrun_gap%0d: valid %b rd %b, required 0 0", i, s_valid, s_rd);
            end
        end
        force_empty = 1'b0;
        run_data(14, 100, 1'b0, n);
        vectors++;
        if (fid !== 1'b0) begin miscompares++; $display("FAIL underrun_fid: got %b, required 0", fid); end
    endtask

    task automatic test_stop();
        int n;
        logic [31:0] pts_before;
        push_words(32'h300, 16);
        push_layout(1'b0);
        run_data(4, 50, 1'b0, n);
        pts_before = last_hdr_pts;
        cam_active = 1'b0;
        cycle();
        vectors++;
        if (s_valid !== 1'b0 || s_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_gate: valid %b rd %b, required 0 0", s_valid, s_rd);
        end
        mon_clear();
        pl_q.delete();
        vectors++;
        if (fid !== 1'b0) begin miscompares++; $display("FAIL stop_fid: got %b, required 0", fid); end
        cam_active = 1'b1;
        push_words(32'h310, 4);
        push_layout(1'b0);
        cycle();
        vectors++;
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL stop_idle: valid %b, required 0", s_valid); end
        run_data(16, 100, 1'b0, n);
        vectors++;
        if (last_hdr_pts == pts_before) begin
            miscompares++;
            $display("FAIL restart_pts: got %h, required != %h", last_hdr_pts, pts_before);
        end
        vectors++;
        if (fid !== 1'b1) begin miscompares++; $display("FAIL restart_fid: got %b, required 1", fid); end
    endtask

    task automatic test_async_reset();
        int n;
        push_words(32'h400, 16);
        push_layout(1'b1);
        run_data(3, 50, 1'b0, n);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_last, fifo_rd_en, fid, out_data} !== 36'h0) begin
            miscompares++;
            $display("FAIL async_reset: got v%b l%b rd%b fid%b d%h, required all 0",
                     out_valid, out_last, fifo_rd_en, fid, out_data);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        tb_stc = '0;
        fifo_q.delete();
        data_q.delete();
        pl_q.delete();
        mon_clear();
        push_words(32'h500, 16);
        push_layout(1'b0);
        run_data(16, 100, 1'b0, n);
        vectors++;
        if (n != 28) begin miscompares++; $display("FAIL post_reset_cycles: got %0d, required 28", n); end
        vectors++;
        if (fid !== 1'b1) begin miscompares++; $display("FAIL post_reset_fid: got %b, required 1", fid); end
    endtask

    initial begin
        logic [31:0] pts1;
        test_reset();
        test_small_frame(pts1);
        test_second_frame(pts1);
        test_backpressure();
        test_underrun();
        test_stop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/uvc_payload_packer.md
# uvc_payload_packer

Packs the 32-bit YUY2 words that the pattern generator writes into the YUV FIFO into UVC bulk payloads, each with a 12-byte UVC payload header. Sits between the YUV FIFO read port and the USB 3.0 bulk-IN endpoint buffer. Tracks frame boundaries so that FID, EOF, PTS and SCR are correct in every header. Provides valid/ready backpressure toward the endpoint.

## Interface
- `WIDTH`, default 1280: pixels per line; must be even.
- `HEIGHT`, default 720: lines per frame.
- `PAYLOAD_WORDS`, default 4093: maximum data words per payload, excluding the header. 4093 = (16384 − 12)/4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cam_active`  in  1  streaming enabled by the host (probe/commit done).
- `fifo_dout`  in  32  YUV FIFO head word; show-ahead, valid whenever `!fifo_empty`.
- `fifo_empty`  in  1  YUV FIFO empty.
- `fifo_rd_en`  out  1  pops the FIFO head this cycle.
- `sof_cnt`  in  11  current USB frame number from the link layer.
- `out_data`  out  32  payload word; byte 0 is in bits [7:0].
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  endpoint accepts the word this cycle.
- `out_last`  out  1  marks the final word of a payload.
- `fid`  out  1  current frame ID, for debug.

## Operation
- FRAME_WORDS = WIDTH*HEIGHT/2.
- Counters:
  - `frame_cnt`: 24 bits, data words sent in the current frame.
  - `pay_cnt`: 16 bits, data words sent in the current payload.
  - `stc`: 32 bits, free-running, +1 every clk. Wraps silently.
- State machine states: IDLE, HDR0, HDR1, HDR2, DATA.
- **IDLE**
  - Transition to HDR0 when `cam_active && !fifo_empty`.
  - On that transition, latch `pay_len` = min(PAYLOAD_WORDS, FRAME_WORDS − frame_cnt).
  - Latch `eof` = (FRAME_WORDS − frame_cnt ≤ PAYLOAD_WORDS).
  - Latch `stc_l` = stc.
  - If frame_cnt==0, also latch `pts` = stc.
- **BFH byte** = {EOH=1, ERR=0, STI=0, RES=0, SCR=1, PTS=1, EOF=eof, FID=fid}.
  - Example: 0x8C when FID=0, EOF=0.
- **Header words:**
  - HDR0 = {pts[15:0], BFH, 8'h0C}.
  - HDR1 = {stc_l[15:0], pts[31:16]}.
  - HDR2 = {5'b0, sof_cnt_l[10:0], stc_l[31:16]}, where `sof_cnt_l` is `sof_cnt` latched at the IDLE→HDR0 transition.
- Each HDRn advances to the next state on `out_valid && out_ready`. HDR2 → DATA.
- **DATA**
  - `out_data = fifo_dout`, `out_valid = !fifo_empty`, `fifo_rd_en = out_valid && out_ready`.
  - On each accepted word, `pay_cnt` and `frame_cnt` increment.
  - `out_last = (pay_cnt == pay_len−1)` while in DATA.
  - On an accepted last word, go to IDLE and clear `pay_cnt`.
  - If `eof` is set: `frame_cnt` ← 0 and `fid` toggles.
- **Stop**: `cam_active` low in any state → next state IDLE.
  - `out_valid` drops the same cycle (combinational gate).
  - `pay_cnt` and `frame_cnt` ← 0. `fid` is unchanged. No pop occurs.
  - The truncated payload is not terminated; the endpoint flushes on stream stop.
- `fifo_rd_en` is never asserted outside DATA.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`.

## Timing
- **Reset values:** state IDLE, `out_valid` 0, `out_last` 0, `fifo_rd_en` 0, `out_data` 0, `fid` 0, all counters 0.
- IDLE condition true in cycle N → HDR0 with `out_valid`=1 in cycle N+1.
- With `out_ready` held high:
  - Header occupies 3 cycles.
  - The first data word appears in cycle N+4.
  - A full payload takes 3 + pay_len cycles, plus one IDLE cycle between payloads.
- FIFO empty in DATA: `out_valid` = 0 (bubble), state held, counters held.
- `out_ready` low: all state held. `out_ready` is honored every cycle, including during headers.
- `fifo_empty` deasserting in the same cycle `cam_active` falls: stop wins, and no pop occurs.

## Test plan
- **Small frame, full throughput.** WIDTH=8, HEIGHT=4, PAYLOAD_WORDS=6, `out_ready`=1, FIFO prefilled with 16 words 0..15.
  - Required: three payloads of 6, 6 and 4 data words.
  - BFH = 0x8C, 0x8C, 0x8E.
  - `out_last` on data words 5, 11 and 15.
- **Second frame.** Continue the first scenario with 16 more words.
  - Required: BFH = 0x8D, 0x8D, 0x8F.
  - The PTS of all three headers equals `stc` at the first header, and differs from the PTS of frame 1.
- **Backpressure.** Toggle `out_ready` 1010… during the header and data phases.
  - Required: no word is lost or duplicated.
  - `out_data` is stable on every not-ready cycle.
  - `fifo_rd_en` count equals 16 per frame.
- **FIFO underrun.** Assert `fifo_empty` for 5 cycles in mid-payload.
  - Required: `out_valid`=0 and `fifo_rd_en`=0 during the gap; the payload resumes with the correct count.
- **Stop mid-payload.** Drop `cam_active` after data word 3.
  - Required: `out_valid` is 0 the same cycle and state is IDLE the next cycle.
  - On restart, the first header carries EOF=0 with the same FID, and PTS is re-latched.
- **Async reset mid-DATA.** Pulse `rst_n` low.
  - Required: all outputs read 0 immediately, independent of `clk`.
